// File: rtl/tick_pwm.sv
// tick_pwm: PWM generator that counts on the tick enable from a pulse divider.
// Period/duty are written through a valid/ready shadow register and take
// effect only at a period wrap (or while idle), so the output never glitches.
// A one-clock cycle_end strobe marks every period wrap.
// Optional feature macro: PWM_DEADTIME_EN enables the complementary pwm_n
// output with DEADTIME clocks of dead-time between the two outputs.
module tick_pwm #(
   parameter int WIDTH    = 16,
   parameter int DEADTIME = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [WIDTH-1:0] cfg_duty,
   output logic             pwm_out,
   output logic             pwm_n,
   output logic             cycle_end
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_act_q, period_act_d;
   logic [WIDTH-1:0] duty_act_q, duty_act_d;
   logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
   logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
   logic             shadow_full_q, shadow_full_d;
   logic             cycle_end_q, cycle_end_d;
   logic             pwm_out_q, pwm_out_d;
   logic             pwm_n_q, pwm_n_d;

   logic             accept_s;
   logic             wrap_s;
   logic             raw_s;

   // A config offer is taken only while the shadow is empty.
   assign accept_s = cfg_valid && !shadow_full_q;
   // Period wrap: counting tick while sitting on the last tick index.
   assign wrap_s   = (state_q == ST_RUN) && tick && (cnt_q == period_act_q);
   // Raw PWM level; cnt never exceeds period_act so the compare cannot overflow.
   assign raw_s    = (state_q == ST_RUN) && (cnt_q < duty_act_q);

   // Next-state logic for the run FSM, tick counter and shadow/active config.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      period_act_d    = period_act_q;
      duty_act_d      = duty_act_q;
      shadow_period_d = shadow_period_q;
      shadow_duty_d   = shadow_duty_q;
      shadow_full_d   = shadow_full_q;
      cycle_end_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = ZERO_W;
            // While idle a filled shadow moves to active on the next clock.
            if (shadow_full_q) begin
               period_act_d  = shadow_period_q;
               duty_act_d    = shadow_duty_q;
               shadow_full_d = 1'b0;
            end else begin
               shadow_full_d = 1'b0;
            end
            // Start decision uses the already-active period.
            if (enable && (period_act_q != ZERO_W)) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (wrap_s) begin
               cnt_d       = ZERO_W;
               cycle_end_d = 1'b1;
               if (shadow_full_q) begin
                  period_act_d  = shadow_period_q;
                  duty_act_d    = shadow_duty_q;
                  shadow_full_d = 1'b0;
                  // A zero period loaded at the wrap stops the generator.
                  if (shadow_period_q == ZERO_W) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  shadow_full_d = 1'b0;
               end
            end else if (tick) begin
               cnt_d = cnt_q + ONE_W;
            end else begin
               cnt_d = cnt_q;
            end
            // Dropping enable wins over everything except the wrap bookkeeping.
            if (!enable) begin
               state_d = ST_IDLE;
               cnt_d   = ZERO_W;
            end else begin
               cycle_end_d = cycle_end_d;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = ZERO_W;
         end
      endcase

      // Accept never collides with a shadow load: ready is low while full.
      if (accept_s) begin
         shadow_period_d = cfg_period;
         shadow_duty_d   = cfg_duty;
         shadow_full_d   = 1'b1;
      end else begin
         shadow_period_d = shadow_period_d;
      end
   end

`ifdef PWM_DEADTIME_EN
   localparam int             DCW    = $clog2(DEADTIME + 2);
   localparam logic [DCW-1:0] DT_LIM = DCW'(DEADTIME);
   localparam logic [DCW-1:0] DT_ONE = DCW'(1);
   localparam logic [DCW-1:0] DT_ZER = DCW'(0);

   // Consecutive low clocks of each output, saturating at DEADTIME.
   logic [DCW-1:0] p_low_q, p_low_d;
   logic [DCW-1:0] n_low_q, n_low_d;

   // Dead-time shaping: rising edges wait for the other side to be low long enough.
   always_comb begin
      pwm_out_d = 1'b0;
      pwm_n_d   = 1'b0;
      p_low_d   = DT_ZER;
      n_low_d   = DT_ZER;
      if (state_q == ST_RUN) begin
         pwm_out_d = raw_s && (n_low_q >= DT_LIM);
         pwm_n_d   = !raw_s && (p_low_q >= DT_LIM);
         if (pwm_out_d) begin
            p_low_d = DT_ZER;
         end else if (p_low_q >= DT_LIM) begin
            p_low_d = p_low_q;
         end else begin
            p_low_d = p_low_q + DT_ONE;
         end
         if (pwm_n_d) begin
            n_low_d = DT_ZER;
         end else if (n_low_q >= DT_LIM) begin
            n_low_d = n_low_q;
         end else begin
            n_low_d = n_low_q + DT_ONE;
         end
      end else begin
         pwm_out_d = 1'b0;
         pwm_n_d   = 1'b0;
      end
   end

   // Dead-time low counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_low_q <= DT_ZER;
         n_low_q <= DT_ZER;
      end else begin
         p_low_q <= p_low_d;
         n_low_q <= n_low_d;
      end
   end
`else
   localparam int dt_unused = DEADTIME;

   // Plain PWM: output follows the compare, complementary pin held low.
   always_comb begin
      pwm_out_d = raw_s;
      pwm_n_d   = 1'b0;
   end
`endif

   // State, counter, config and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= ZERO_W;
         period_act_q    <= ZERO_W;
         duty_act_q      <= ZERO_W;
         shadow_period_q <= ZERO_W;
         shadow_duty_q   <= ZERO_W;
         shadow_full_q   <= 1'b0;
         cycle_end_q     <= 1'b0;
         pwm_out_q       <= 1'b0;
         pwm_n_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         period_act_q    <= period_act_d;
         duty_act_q      <= duty_act_d;
         shadow_period_q <= shadow_period_d;
         shadow_duty_q   <= shadow_duty_d;
         shadow_full_q   <= shadow_full_d;
         cycle_end_q     <= cycle_end_d;
         pwm_out_q       <= pwm_out_d;
         pwm_n_q         <= pwm_n_d;
      end
   end

   assign cfg_ready = !shadow_full_q;
   assign pwm_out   = pwm_out_q;
   assign pwm_n     = pwm_n_q;
   assign cycle_end = cycle_end_q;

endmodule
